// File: rtl/pt_pkg.sv
// Shared Pan-Tompkins definitions: sample type, derivative kernel constants
// and the priming state encoding used by the derivative stage.
package pt_pkg;

    localparam int DEF_DATA_WIDTH  = 11;
    localparam int DERIV_SHIFT     = 3;
    localparam int DERIV_PRIME_CNT = 4;

    typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;

    typedef enum logic {
        PRIME,
        RUN
    } deriv_state_t;

endpackage

// File: rtl/deriv_tap_line.sv
// Four-deep sample history for the derivative kernel; shifts only on an
// accepted input and is flushed by reset or clear.
module deriv_tap_line
    import pt_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] x1,
    output logic [DATA_WIDTH-1:0] x2,
    output logic [DATA_WIDTH-1:0] x3,
    output logic [DATA_WIDTH-1:0] x4
);

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            x1 <= '0;
            x2 <= '0;
            x3 <= '0;
            x4 <= '0;
        end else if (shift) begin
            x4 <= x3;
            x3 <= x2;
            x2 <= x1;
            x1 <= din;
        end
    end

endmodule

// File: rtl/derivative_filter.sv
// Pan-Tompkins derivative y(n) = (2x(n) + x(n-1) - x(n-3) - 2x(n-4)) / 8 with a
// valid/ready stream, two-stage pipeline and priming FSM. DERIV_ROUND_EN selects round-half-up.
module derivative_filter
    import pt_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
);

    localparam int SUM_WIDTH = DATA_WIDTH + 3;

    logic [DATA_WIDTH-1:0]        x1, x2, x3, x4;
    logic signed [SUM_WIDTH-1:0]  sum_p0;
    logic signed [SUM_WIDTH-1:0]  sum_p1;
    logic                         vld_p1;
    logic [DATA_WIDTH-1:0]        data_p2;
    logic                         vld_p2;
    deriv_state_t                 state;
    logic [2:0]                   prime_cnt;
    logic                         stall;
    logic                         advance;
    logic                         accept;
    logic                         run_now;

    function automatic logic signed [SUM_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] v);
        return {{(SUM_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] scale(input logic signed [SUM_WIDTH-1:0] s);
        logic signed [SUM_WIDTH-1:0] t;
`ifdef DERIV_ROUND_EN
        t = s + $signed(SUM_WIDTH'(1 << (DERIV_SHIFT - 1)));
`else
        t = s;
`endif
        t = t >>> DERIV_SHIFT;
        return t[DATA_WIDTH-1:0];
    endfunction

    assign stall     = vld_p2 && !out_ready;
    assign advance   = en && !stall;
    assign in_ready  = en && !clear && !stall;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_p2 && en;
    assign out_data  = data_p2;

    // The accept that completes priming already sees a full four-sample history.
    assign run_now = (state == RUN) || (prime_cnt == 3'(DERIV_PRIME_CNT));

    deriv_tap_line #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_taps (
        .clk  (clk),
        .rstn (rstn),
        .clear(clear),
        .shift(accept),
        .din  (in_data),
        .x1   (x1),
        .x2   (x2),
        .x3   (x3),
        .x4   (x4)
    );

    // x(n-2) has a zero coefficient in this kernel.
    logic unused_x2;
    assign unused_x2 = ^x2;

    assign sum_p0 = (sext(in_data) <<< 1) + sext(x1) - sext(x3) - (sext(x4) <<< 1);

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            sum_p1    <= '0;
            vld_p1    <= 1'b0;
            data_p2   <= '0;
            vld_p2    <= 1'b0;
            state     <= PRIME;
            prime_cnt <= '0;
        end else if (advance) begin
            // stage 1: tap sum
            sum_p1 <= sum_p0;
            vld_p1 <= accept && run_now;
            // stage 2: scale to output width
            data_p2 <= scale(sum_p1);
            vld_p2  <= vld_p1;
            if (accept && state == PRIME) begin
                if (prime_cnt == 3'(DERIV_PRIME_CNT))
                    state <= RUN;
                else
                    prime_cnt <= prime_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_derivative_filter.sv
// Self-checking bench for derivative_filter: directed scenarios plus random
// traffic scored against a sample-history reference model.
module tb_derivative_filter;

    localparam int DW = 11;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          clear;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int n_xfer  = 0;
    int cycle   = 0;
    bit lat_chk = 1'b0;
    bit acc;

    int hist[$];
    int exp_q[$];
    int acc_cyc[$];

    derivative_filter #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int floor_div8(input int v);
        int q;
        q = v / 8;
        if ((v % 8 != 0) && (v < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int model_out(input int x0, input int xm1, input int xm3, input int xm4);
        int v;
        v = 2 * x0 + xm1 - xm3 - 2 * xm4;
`ifdef DERIV_ROUND_EN
        v = v + 4;
`endif
        return floor_div8(v);
    endfunction

    // One clock: observe handshakes mid-cycle, then advance past the edge.
    task automatic tick();
        bit xfer;
        int x, e, c;
        #3;
        acc  = in_valid && in_ready;
        xfer = out_valid && out_ready;
        if (xfer) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("spurious_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                c = acc_cyc.pop_front();
                check("out_data", int'($signed(out_data)), e);
                if (lat_chk) check("latency", cycle - c, 2);
            end
        end
        if (acc) begin
            x = int'($signed(in_data));
            if (hist.size() >= 4) begin
                exp_q.push_back(model_out(x, hist[3], hist[1], hist[0]));
                acc_cyc.push_back(cycle);
            end
            hist.push_back(x);
            if (hist.size() > 4) void'(hist.pop_front());
        end
        @(posedge clk);
        #1;
        cycle++;
        if (!rstn || clear) begin
            hist.delete();
            exp_q.delete();
            acc_cyc.delete();
        end
    endtask

    task automatic send(input int x);
        int guard;
        in_valid = 1'b1;
        in_data  = DW'(x);
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!acc && guard < 50);
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        int held, x, base;
        rstn = 1'b0; en = 1'b1; clear = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) tick();
        rstn = 1'b1;
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'($signed(out_data)), 0);
        check("reset_in_ready", int'(in_ready), 1);

        // Ramp: first four accepts prime, then one output per accept.
        lat_chk = 1'b1;
        n_xfer = 0;
        for (int i = 0; i < 6; i++) send(10 * i);
        drain();
        check("ramp_count", n_xfer, 2);
        check("ramp_left", exp_q.size(), 0);

        // Constant input gives a zero derivative once primed.
        do_clear();
        n_xfer = 0;
        for (int i = 0; i < 10; i++) send(500);
        drain();
        check("const_count", n_xfer, 6);

        // Full-scale extremes in both directions.
        do_clear();
        n_xfer = 0;
        send(-1024); send(-1024); send(0); send(1023); send(1023);
        drain();
        do_clear();
        send(1023); send(1023); send(0); send(-1024); send(-1024);
        drain();
        check("extreme_count", n_xfer, 2);

        // Backpressure mid-stream.
        do_clear();
        lat_chk = 1'b0;
        base = $urandom_range(0, 100);
        for (int i = 0; i < 7; i++) send(base + 37 * i);
        check("bp_valid_before", int'(out_valid), 1);
        held = int'($signed(out_data));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(base + 37 * 7);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_data", int'($signed(out_data)), held);
        end
        out_ready = 1'b1;
        for (int i = 7; i < 12; i++) send(base + 37 * i);
        drain();
        check("bp_left", exp_q.size(), 0);

        // Clear with a sample offered while running.
        for (int i = 0; i < 6; i++) send(int'($urandom_range(0, 2047)) - 1024);
        clear = 1'b1; in_valid = 1'b1; in_data = DW'(77);
        #1;
        check("clear_in_ready", int'(in_ready), 0);
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clear_out_valid", int'(out_valid), 0);
        n_xfer = 0;
        for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 2047)) - 1024);
        drain();
        check("clear_reprime", n_xfer, 0);
        send(int'($urandom_range(0, 2047)) - 1024);
        drain();
        check("clear_first_out", n_xfer, 1);

        // Enable low mid-stream keeps history.
        for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 2047)) - 1024);
        en = 1'b0; in_valid = 1'b1; in_data = DW'(300);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("en_in_ready", int'(in_ready), 0);
            check("en_out_valid", int'(out_valid), 0);
            tick();
        end
        en = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 2047)) - 1024);
        drain();
        check("en_left", exp_q.size(), 0);

        // Random traffic with random gaps and backpressure.
        do_clear();
        n_xfer = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            x = int'($urandom_range(0, 2047)) - 1024;
            if (!in_valid || acc) in_data = DW'(x);
            tick();
        end
        drain();
        check("rand_left", exp_q.size(), 0);

        // Reset mid-stream drops pending samples and restarts priming.
        for (int i = 0; i < 6; i++) send(int'($urandom_range(0, 2047)) - 1024);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        n_xfer = 0;
        for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 2047)) - 1024);
        drain();
        check("rst_reprime", n_xfer, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
